// File: rtl/spi_slave_mode.sv
// spi_slave_mode -- run-time CPOL/CPHA SPI slave with word-stream framing and double-buffered TX.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module spi_slave_mode #(
  parameter int WORD_SIZE   = 16,
  parameter int WORD_BITS   = $clog2(WORD_SIZE),
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cpol,
  input  logic                 i_cpha,
  input  logic                 i_sck,
  input  logic                 i_sce,
  input  logic                 i_sin,
  output logic                 o_sout,
  output logic                 o_soe,
  input  logic [WORD_SIZE-1:0] i_win,
  input  logic                 i_wvalid,
  output logic                 o_wready,
  output logic [WORD_SIZE-1:0] o_wout,
  output logic                 o_wstb,
  output logic                 o_urun,
  output logic                 o_ferr,
  output logic                 o_busy
);

  localparam logic [WORD_BITS-1:0] c_LAST_BIT = WORD_BITS'(WORD_SIZE - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sce_sync;
  logic [SYNC_STAGES-1:0] r_sin_sync;
  logic                   r_sck_d;
  logic                   r_sce_d;
  logic                   r_cpol_l;
  logic                   r_cpha_l;
  logic [WORD_SIZE-1:0]   r_rx_sr;
  logic [WORD_SIZE-1:0]   r_tx_sr;
  logic [WORD_SIZE-1:0]   r_hold;
  logic                   r_hold_full;
  logic [WORD_SIZE-1:0]   r_wout;
  logic [WORD_BITS-1:0]   r_cnt;
  logic                   r_word_done;
  logic                   r_wstb;
  logic                   r_urun;
  logic                   r_ferr;
  logic                   r_busy;

  logic                 w_sck;
  logic                 w_sce;
  logic                 w_sin;
  logic                 w_active;
  logic                 w_ce_fall;
  logic                 w_ce_rise;
  logic                 w_nclk;
  logic                 w_nclk_d;
  logic                 w_lead;
  logic                 w_trail;
  logic                 w_sample;
  logic                 w_shift;
  logic                 w_last;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_tx_bit;
  logic [WORD_SIZE-1:0] w_rx_next;
  logic [WORD_SIZE-1:0] w_tx_shifted;

  assign w_sck     = r_sck_sync[SYNC_STAGES-1];
  assign w_sce     = r_sce_sync[SYNC_STAGES-1];
  assign w_sin     = r_sin_sync[SYNC_STAGES-1];
  assign w_active  = (r_state == ST_ACTIVE);
  assign w_ce_fall = ~w_sce & r_sce_d;
  assign w_ce_rise = w_sce & ~r_sce_d;

  // Both samples use the latched polarity, so a mode change never fakes an edge.
  assign w_nclk   = w_sck ^ r_cpol_l;
  assign w_nclk_d = r_sck_d ^ r_cpol_l;
  assign w_lead   = w_nclk & ~w_nclk_d;
  assign w_trail  = ~w_nclk & w_nclk_d;
  assign w_sample = w_active & (r_cpha_l ? w_trail : w_lead);
  assign w_shift  = w_active & (r_cpha_l ? w_lead : w_trail);
  assign w_last   = (r_cnt == c_LAST_BIT);

  assign w_rx_next    = LSB_FIRST ? {w_sin, r_rx_sr[WORD_SIZE-1:1]}
                                  : {r_rx_sr[WORD_SIZE-2:0], w_sin};
  assign w_tx_shifted = LSB_FIRST ? {1'b0, r_tx_sr[WORD_SIZE-1:1]}
                                  : {r_tx_sr[WORD_SIZE-2:0], 1'b0};
  assign w_tx_bit     = LSB_FIRST ? r_tx_sr[0] : r_tx_sr[WORD_SIZE-1];

  // CPHA=0 needs the first bit on the wire before the first edge, so it loads at CE fall.
  assign w_load   = (~w_active & w_ce_fall & ~i_cpha)
                  | (w_shift & (r_cpha_l ? (r_cnt == '0) : r_word_done));
  assign w_accept = i_wvalid & ~r_hold_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_sck_sync  <= '0;
      r_sce_sync  <= '0;
      r_sin_sync  <= '0;
      r_sck_d     <= 1'b0;
      r_sce_d     <= 1'b0;
      r_cpol_l    <= 1'b0;
      r_cpha_l    <= 1'b0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_wout      <= '0;
      r_cnt       <= '0;
      r_word_done <= 1'b0;
      r_wstb      <= 1'b0;
      r_urun      <= 1'b0;
      r_ferr      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_sce_sync <= {r_sce_sync[SYNC_STAGES-2:0], i_sce};
      r_sin_sync <= {r_sin_sync[SYNC_STAGES-2:0], i_sin};
      r_sck_d    <= w_sck;
      r_sce_d    <= w_sce;
      r_wstb     <= 1'b0;
      r_urun     <= 1'b0;
      r_ferr     <= 1'b0;

      if (w_load) begin
        if (r_hold_full) begin
          r_tx_sr <= r_hold;
        end else begin
          r_tx_sr <= '0;
          r_urun  <= 1'b1;
        end
      end else if (w_shift) begin
        r_tx_sr <= w_tx_shifted;
      end

      if (w_accept) begin
        r_hold      <= i_win;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_ce_fall) begin
            r_state     <= ST_ACTIVE;
            r_busy      <= 1'b1;
            r_cpol_l    <= i_cpol;
            r_cpha_l    <= i_cpha;
            r_cnt       <= '0;
            r_rx_sr     <= '0;
            r_word_done <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (w_sample) begin
            r_rx_sr <= w_rx_next;
            if (w_last) begin
              r_cnt       <= '0;
              r_wout      <= w_rx_next;
              r_wstb      <= 1'b1;
              r_word_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          if (w_shift) begin
            r_word_done <= 1'b0;
          end
          // A word completing in the same cycle as CE rise is a clean end, not an error.
          if (w_ce_rise) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_rx_sr     <= '0;
            r_word_done <= 1'b0;
            r_ferr      <= w_sample ? ~w_last : (r_cnt != '0);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sout   = w_active & w_tx_bit;
  assign o_soe    = r_busy;
  assign o_busy   = r_busy;
  assign o_wready = ~r_hold_full;
  assign o_wout   = r_wout;
  assign o_wstb   = r_wstb;
  assign o_urun   = r_urun;
  assign o_ferr   = r_ferr;

endmodule

`default_nettype wire
